// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Purpose  : Multi-cycle sequencer for MIPS DIV/DIVU in the execute stage.
//            Latches the operands on accept and runs a WIDTH-iteration
//            radix-2 restoring division on operand magnitudes. Stalls the
//            pipeline while busy, then presents {remainder, quotient}
//            for the HI/LO write. An annul (exception flush) cancels the
//            operation without touching the result.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            start_i   - DIV/DIVU present in EX (level, held while stalled)
//            signed_i  - 1 = DIV (signed), 0 = DIVU
//            opa_i     - dividend (rs), sampled on accept only
//            opb_i     - divisor (rt), sampled on accept only
//            annul_i   - flush; cancels any operation in flight
//            result_o  - {remainder -> HI, quotient -> LO}, registered
//            ready_o   - one-cycle pulse, result_o valid
//            stall_o   - freeze PC/IF/ID/EX
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_stIdle    = 2'd0;
    localparam logic [1:0] c_stDivZero = 2'd1;
    localparam logic [1:0] c_stOn      = 2'd2;
    localparam logic [1:0] c_stEnd     = 2'd3;

    localparam logic [CNT_W-1:0] c_cntLast = CNT_W'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_rem;      // partial remainder, always < divisor
    logic [WIDTH-1:0]     r_dvd;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]     r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]     r_opaRaw;   // raw dividend, reported as remainder on /0
    logic                 r_negQ;
    logic                 r_negR;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_nextRem;
    logic [WIDTH-1:0]     w_nextQuo;
    logic [WIDTH-1:0]     w_finalQuo;
    logic [WIDTH-1:0]     w_finalRem;

    assign w_accept = start_i & ~annul_i;

    // Magnitudes; negation is modulo 2^WIDTH so the most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    assign w_absA = (signed_i & opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign w_absB = (signed_i & opb_i[WIDTH-1]) ? -opb_i : opb_i;

    // One restoring step: shift the next dividend bit into the remainder
    // and trial-subtract with one extra bit so the borrow shows up as sign.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_fits     = ~w_trial[WIDTH];
    assign w_nextRem  = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_nextQuo  = {r_dvd[WIDTH-2:0], w_fits};

    // Sign fix-up applied to the values produced by the final step.
    assign w_finalQuo = r_negQ ? -w_nextQuo : w_nextQuo;
    assign w_finalRem = r_negR ? -w_nextRem : w_nextRem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_stIdle;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_opaRaw <= '0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
            r_result <= '0;
        end else if (annul_i) begin
            // Flush wins over everything; result is deliberately untouched.
            r_state <= c_stIdle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (start_i) begin
                        r_negQ   <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        r_negR   <= signed_i & opa_i[WIDTH-1];
                        r_opaRaw <= opa_i;
                        r_dvd    <= w_absA;
                        r_dvs    <= w_absB;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_state  <= (opb_i == '0) ? c_stDivZero : c_stOn;
                    end
                end
                c_stDivZero: begin
                    r_result <= {r_opaRaw, {WIDTH{1'b1}}};
                    r_state  <= c_stEnd;
                end
                c_stOn: begin
                    r_rem <= w_nextRem;
                    r_dvd <= w_nextQuo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_cntLast) begin
                        r_result <= {w_finalRem, w_finalQuo};
                        r_state  <= c_stEnd;
                    end
                end
                default: begin
                    r_state <= c_stIdle;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == c_stEnd);
    // Only the IDLE term looks at inputs; END never stalls so the pipeline
    // advances on the edge that closes the ready cycle.
    assign stall_o  = ~rst & (((r_state == c_stIdle) & w_accept) |
                              (r_state == c_stDivZero) |
                              (r_state == c_stOn));

endmodule
`default_nettype wire
